song_sequencer: RTL and testbench
=================================

// Module: song_sequencer
// PURPOSE
//  Auto-play stage directly upstream of the buzzer tone generator. Walks a song ROM and
//  drives the buzzer's note/pitch/stop inputs, one entry at a time. Each entry is held
//  for its duration, then a short silent gap follows so that repeated notes stay distinct.
//  Supports start/abort/pause/loop and three tempo settings; ends on an end marker.
// PARAMETERS
//  UNIT_CYCLES  12_500_000  clk cycles per duration unit at normal tempo (1/8 s @100 MHz)
//  GAP_CYCLES   1_000_000   silent cycles at end of every entry; must be < UNIT_CYCLES/2
//  SONG_LEN     64          ROM depth in entries
//  ADDR_W       6           clog2(SONG_LEN)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous, active-low reset
//  start      in   1  1-cycle pulse: begin song from entry 0
//  abort      in   1  level: return to IDLE, silence output
//  pause      in   1  level: freeze timing, assert stop
//  loop_en    in   1  restart at entry 0 instead of finishing
//  speed      in   2  00/11 normal, 01 fast (unit>>1), 10 slow (unit<<1)
//  note       out  7  one-hot note to buzzer; 0 = silent
//  pitch      out  3  one-hot octave to buzzer (001 low, 010 mid, 100 high)
//  stop       out  1  freeze buzzer
//  playing    out  1  high in FETCH/PLAY/GAP
//  done       out  1  high in DONE
//  entry_idx  out  ADDR_W  ROM address of the current entry
// BEHAVIOUR
//  Reset: state=IDLE, note=0, pitch=3'b010, stop=1, playing=0, done=0, entry_idx=0, counters=0.
//  ROM entry: 14 b = {dur[13:10], pitch[9:7], note[6:0]}. dur=0 is the end marker.
//   note=0 is a rest. A pitch that is not one-hot is replaced by 3'b010.
//  Unit length U is sampled at entry load: normal UNIT_CYCLES, fast UNIT_CYCLES>>1,
//   slow UNIT_CYCLES<<1. Tone length T = dur*U - GAP_CYCLES, computed in 32 b unsigned.
//  FSM:
//   IDLE : note=0, stop=1. On start, go to FETCH with addr=0.
//   FETCH: 1 cycle for the synchronous ROM read. If data is the end marker:
//           loop_en=1 -> FETCH addr 0; else DONE.
//          Otherwise register note/pitch and go to PLAY with cnt=0.
//   PLAY : outputs hold the entry, stop=0. When cnt reaches T-1, go to GAP.
//   GAP  : note=0, stop=0, pitch held. When cnt reaches GAP_CYCLES-1:
//           addr==SONG_LEN-1 -> same as end marker; else addr+1 -> FETCH.
//   DONE : note=0, stop=1, done=1. On start, go to FETCH addr 0.
//  Latency: start -> first note visible on note = 2 clk edges (IDLE->FETCH->PLAY).
//   Between entries: GAP, then 1 FETCH cycle of silence.
//  pause=1 in PLAY/GAP: cnt holds, stop=1, note/pitch hold. Release resumes with no lost
//   cycles. pause is ignored in other states.
//  abort=1: IDLE on the next edge from any state; it has priority over start and pause.
//  start in FETCH/PLAY/GAP is ignored. Changing speed mid-entry takes effect at the next load.
//  A reset mid-song returns to the reset values immediately, with no partial note.
// STRUCTURE
//  Shared include piano_defs.vh: entry field offsets/widths, PITCH_LOW/MID/HIGH,
//   SPEED_* codes, FSM state encodings.
//  Sub-module song_rom (ADDR_W in, 14 b out, registered read, contents via $readmemb).
//  Top level holds the FSM, the 32 b cnt, the T/U computation and the output registers.
// TESTING (sim params UNIT_CYCLES=10, GAP_CYCLES=2, SONG_LEN=4)
//  ROM {dur1 mid do, dur2 high re, end}, start pulse -> note=0000001 for 8 cyc, gap 2,
//   fetch 1, then note=0000010 pitch=100 for 18 cyc, then DONE with done=1, stop=1.
//  Same ROM with loop_en=1 -> after entry 1's gap, entry_idx=0 and do replays; done stays 0.
//  pause held 5 cyc at PLAY cnt=3 -> stop=1 and note held for those 5 cyc; note still ends
//   8 active cycles after its start, i.e. 5 cycles later than without the pause.
//  speed=01 on dur2 entry -> tone 8 cyc; speed=10 -> tone 38 cyc.
//  abort and start asserted together in PLAY -> IDLE, note=0, stop=1; start is ignored.
//  rst_n low mid-PLAY -> all outputs at reset values asynchronously.
//  Full 4-entry ROM with no end marker -> wraps or ends after entry_idx=3 per loop_en.
//  Invalid pitch 3'b011 -> pitch=010.

Source files
------------

// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: ROM entry layout, pitch and speed codes,
// FSM states and the pitch sanitising helper.
package song_sequencer_pkg;

  localparam int ENTRY_W   = 14;
  localparam int DUR_LSB   = 10;
  localparam int DUR_W     = 4;
  localparam int PITCH_LSB = 7;
  localparam int PITCH_W   = 3;
  localparam int NOTE_W    = 7;

  localparam logic [2:0] PITCH_LOW  = 3'b001;
  localparam logic [2:0] PITCH_MID  = 3'b010;
  localparam logic [2:0] PITCH_HIGH = 3'b100;

  localparam logic [1:0] SPEED_NORMAL = 2'b00;
  localparam logic [1:0] SPEED_FAST   = 2'b01;
  localparam logic [1:0] SPEED_SLOW   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  // The buzzer only understands one-hot octaves; anything else falls back to mid.
  function automatic logic [2:0] fix_pitch(input logic [2:0] p);
    case (p)
      PITCH_LOW, PITCH_MID, PITCH_HIGH: return p;
      default:                          return PITCH_MID;
    endcase
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song ROM with a registered read port; contents are supplied as a packed parameter,
// entry i occupying bits [ENTRY_W*i +: ENTRY_W].
module song_rom
  import song_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned SONG_LEN = 64,
  parameter logic [ENTRY_W*SONG_LEN-1:0] INIT = '0
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] data
);

  logic [ENTRY_W-1:0] mem [SONG_LEN];

  for (genvar i = 0; i < SONG_LEN; i++) begin : g_mem
    assign mem[i] = INIT[i*ENTRY_W +: ENTRY_W];
  end

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/song_sequencer.sv
// Auto-play sequencer: walks the song ROM, holds each entry for dur*unit cycles minus a
// trailing silent gap, and drives the buzzer's note/pitch/stop inputs.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned SONG_LEN    = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter logic [ENTRY_W*SONG_LEN-1:0] ROM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [1:0]        speed,
  output logic [6:0]        note,
  output logic [2:0]        pitch,
  output logic              stop,
  output logic              playing,
  output logic              done,
  output logic [ADDR_W-1:0] entry_idx
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [31:0]       GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0]       UNIT_NORM = 32'(UNIT_CYCLES);

  state_t               state;
  logic [31:0]          cnt;
  logic [31:0]          tone_last;
  logic [31:0]          unit_len;
  logic [ADDR_W-1:0]    rom_addr;
  logic [ENTRY_W-1:0]   rom_data;
  logic [DUR_W-1:0]     rom_dur;
  logic [PITCH_W-1:0]   rom_pitch;
  logic [NOTE_W-1:0]    rom_note;
  logic                 end_marker;
  logic                 last_entry;

  song_rom #(
    .ADDR_W   (ADDR_W),
    .SONG_LEN (SONG_LEN),
    .INIT     (ROM_INIT)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  assign rom_dur    = rom_data[DUR_LSB +: DUR_W];
  assign rom_pitch  = rom_data[PITCH_LSB +: PITCH_W];
  assign rom_note   = rom_data[NOTE_W-1:0];
  assign end_marker = (rom_dur == '0);
  assign last_entry = (entry_idx == LAST_ADDR);

  // The ROM is presented with the address the FSM is about to load so that its
  // registered output is valid during the single FETCH cycle.
  always_comb begin
    rom_addr = entry_idx;
    case (state)
      S_IDLE, S_DONE: rom_addr = '0;
      S_FETCH:        if (end_marker) rom_addr = '0;
      S_GAP:          rom_addr = last_entry ? '0 : entry_idx + 1'b1;
      default:        ;
    endcase
  end

  always_comb begin
    case (speed)
      SPEED_FAST: unit_len = UNIT_NORM >> 1;
      SPEED_SLOW: unit_len = UNIT_NORM << 1;
      SPEED_NORMAL: unit_len = UNIT_NORM;
      default:    unit_len = UNIT_NORM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      note      <= '0;
      pitch     <= PITCH_MID;
      stop      <= 1'b1;
      playing   <= 1'b0;
      done      <= 1'b0;
      entry_idx <= '0;
      cnt       <= '0;
      tone_last <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      note      <= '0;
      stop      <= 1'b1;
      playing   <= 1'b0;
      done      <= 1'b0;
      entry_idx <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_FETCH;
            entry_idx <= '0;
            playing   <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_FETCH: begin
          if (end_marker) begin
            if (loop_en) begin
              entry_idx <= '0;
            end else begin
              state   <= S_DONE;
              playing <= 1'b0;
              done    <= 1'b1;
              stop    <= 1'b1;
            end
          end else begin
            state     <= S_PLAY;
            note      <= rom_note;
            pitch     <= fix_pitch(rom_pitch);
            stop      <= 1'b0;
            cnt       <= '0;
            tone_last <= 32'(rom_dur) * unit_len - GAP_CYCLES - 32'd1;
          end
        end
        S_PLAY: begin
          stop <= pause;
          if (!pause) begin
            if (cnt == tone_last) begin
              state <= S_GAP;
              note  <= '0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        S_GAP: begin
          stop <= pause;
          if (!pause) begin
            if (cnt == GAP_LAST) begin
              cnt <= '0;
              if (!last_entry) begin
                state     <= S_FETCH;
                entry_idx <= entry_idx + 1'b1;
              end else if (loop_en) begin
                state     <= S_FETCH;
                entry_idx <= '0;
              end else begin
                state   <= S_DONE;
                playing <= 1'b0;
                done    <= 1'b1;
                stop    <= 1'b1;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: two instances with different ROMs share one stimulus stream
// and are compared every cycle against a timeline model of the song.
module tb_song_sequencer;

  localparam int UNIT = 10;
  localparam int GAP  = 2;
  localparam int LEN  = 4;
  localparam int AW   = 2;

  // A: {dur1 mid do, dur2 high re, end, unreachable}; B: four entries, no end marker,
  // first entry carries the invalid pitch 011, second is a rest.
  localparam logic [55:0] ROM_A = {14'b0011_001_0000100, 14'b0000_000_0000000,
                                   14'b0010_100_0000010, 14'b0001_010_0000001};
  localparam logic [55:0] ROM_B = {14'b0001_010_1000000, 14'b0010_100_0100000,
                                   14'b0001_001_0000000, 14'b0001_011_0001000};
  localparam logic [14:0] RST_V = {7'b0, 3'b010, 1'b1, 1'b0, 1'b0, 2'b00};
  localparam logic [6:0]  DO = 7'b0000001;
  localparam logic [6:0]  RE = 7'b0000010;

  localparam int P_IDLE = 0, P_FETCH = 1, P_TONE = 2, P_GAP = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [1:0] speed = 2'b00;

  logic [6:0] note_a, note_b;
  logic [2:0] pitch_a, pitch_b;
  logic stop_a, stop_b, playing_a, playing_b, done_a, done_b;
  logic [AW-1:0] idx_a, idx_b;
  logic [14:0] obs_a, obs_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  song_sequencer #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP), .SONG_LEN(LEN), .ADDR_W(AW),
                   .ROM_INIT(ROM_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .loop_en(loop_en), .speed(speed), .note(note_a), .pitch(pitch_a), .stop(stop_a),
    .playing(playing_a), .done(done_a), .entry_idx(idx_a));

  song_sequencer #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP), .SONG_LEN(LEN), .ADDR_W(AW),
                   .ROM_INIT(ROM_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .loop_en(loop_en), .speed(speed), .note(note_b), .pitch(pitch_b), .stop(stop_b),
    .playing(playing_b), .done(done_b), .entry_idx(idx_b));

  assign obs_a = {note_a, pitch_a, stop_a, playing_a, done_a, idx_a};
  assign obs_b = {note_b, pitch_b, stop_b, playing_b, done_b, idx_b};

  // Reference model: each song is a sequence of (tone, gap, fetch) segments whose lengths
  // come from dur*unit-GAP; m_left counts down the cycles left in the current segment.
  logic [13:0]   rom [2][4];
  int            m_ph [2];
  int            m_left [2];
  logic [AW-1:0] m_idx [2];
  logic [6:0]    m_note [2];
  logic [2:0]    m_pitch [2];
  logic          m_stop [2], m_play [2], m_done [2];
  logic [13:0]   m_e;

  function automatic int unit_of(input logic [1:0] s);
    if (s == 2'b01) return UNIT / 2;
    if (s == 2'b10) return UNIT * 2;
    return UNIT;
  endfunction

  function automatic logic [14:0] expv(input int k);
    return {m_note[k], m_pitch[k], m_stop[k], m_play[k], m_done[k], m_idx[k]};
  endfunction

  task automatic end_song(input int k);
    if (loop_en) begin
      m_ph[k] = P_FETCH;
      m_idx[k] = '0;
    end else begin
      m_ph[k] = P_DONE;
      m_play[k] = 1'b0;
      m_done[k] = 1'b1;
      m_stop[k] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ph[k] = P_IDLE; m_left[k] = 0; m_idx[k] = '0; m_note[k] = '0;
        m_pitch[k] = 3'b010; m_stop[k] = 1'b1; m_play[k] = 1'b0; m_done[k] = 1'b0;
      end else if (abort) begin
        m_ph[k] = P_IDLE; m_idx[k] = '0; m_note[k] = '0;
        m_stop[k] = 1'b1; m_play[k] = 1'b0; m_done[k] = 1'b0;
      end else if (m_ph[k] == P_IDLE || m_ph[k] == P_DONE) begin
        if (start) begin
          m_ph[k] = P_FETCH; m_idx[k] = '0; m_play[k] = 1'b1; m_done[k] = 1'b0;
        end
      end else if (m_ph[k] == P_FETCH) begin
        m_e = rom[k][m_idx[k]];
        if (m_e[13:10] == 4'd0) begin
          end_song(k);
        end else begin
          m_ph[k] = P_TONE;
          m_note[k] = m_e[6:0];
          m_pitch[k] = ($countones(m_e[9:7]) == 1) ? m_e[9:7] : 3'b010;
          m_stop[k] = 1'b0;
          m_left[k] = int'(m_e[13:10]) * unit_of(speed) - GAP;
        end
      end else begin
        m_stop[k] = pause;
        if (!pause) begin
          m_left[k] = m_left[k] - 1;
          if (m_left[k] == 0) begin
            if (m_ph[k] == P_TONE) begin
              m_ph[k] = P_GAP; m_note[k] = '0; m_left[k] = GAP;
            end else if (m_idx[k] == AW'(LEN - 1)) begin
              end_song(k);
            end else begin
              m_idx[k] = m_idx[k] + 1'b1;
              m_ph[k] = P_FETCH;
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors += 2;
    if (obs_a !== RST_V) begin miscompares++; $display("FAIL reset_a got %h exp %h", obs_a, RST_V); end
    if (obs_b !== RST_V) begin miscompares++; $display("FAIL reset_b got %h exp %h", obs_b, RST_V); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs_a !== RST_V) begin miscompares++; $display("FAIL idle_after_reset got %h exp %h", obs_a, RST_V); end
  endtask

  task automatic test_basic_song;
    int do_cyc = 0, re_cyc = 0;
    loop_en = 1'b0; speed = 2'b00; start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      vectors += 2;
      if (obs_a !== expv(0)) begin miscompares++; $display("FAIL basic_a c=%0d got %h exp %h", c, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin miscompares++; $display("FAIL basic_b c=%0d got %h exp %h", c, obs_b, expv(1)); end
      if (note_a == DO && pitch_a == 3'b010) do_cyc++;
      if (note_a == RE && pitch_a == 3'b100) re_cyc++;
      if (c == 1) begin
        vectors += 2;
        if (note_a !== DO) begin miscompares++; $display("FAIL latency got %b exp %b", note_a, DO); end
        if ({note_b, pitch_b} !== {7'b0001000, 3'b010}) begin
          miscompares++; $display("FAIL bad_pitch got %b/%b exp 0001000/010", note_b, pitch_b);
        end
      end
      start = 1'b0;
    end
    vectors += 4;
    if (do_cyc !== 8) begin miscompares++; $display("FAIL do_len got %0d exp 8", do_cyc); end
    if (re_cyc !== 18) begin miscompares++; $display("FAIL re_len got %0d exp 18", re_cyc); end
    if ({done_a, stop_a, playing_a} !== 3'b110) begin
      miscompares++; $display("FAIL done_a got %b exp 110", {done_a, stop_a, playing_a});
    end
    if ({done_b, idx_b} !== {1'b1, 2'd3}) begin
      miscompares++; $display("FAIL done_b got %b exp 111", {done_b, idx_b});
    end
  endtask

  task automatic test_loop;
    int rises = 0;
    logic prev_do = 1'b0;
    logic saw_done = 1'b0;
    loop_en = 1'b1; start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      vectors += 2;
      if (obs_a !== expv(0)) begin miscompares++; $display("FAIL loop_a c=%0d got %h exp %h", c, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin miscompares++; $display("FAIL loop_b c=%0d got %h exp %h", c, obs_b, expv(1)); end
      if (note_a == DO && !prev_do) rises++;
      prev_do = (note_a == DO);
      saw_done = saw_done | done_a;
      if (c == 33) begin
        vectors++;
        if ({idx_a, playing_a} !== 3'b001) begin miscompares++; $display("FAIL loop_idx_a got %b exp 001", {idx_a, playing_a}); end
      end
      if (c == 54) begin
        vectors++;
        if ({idx_b, playing_b, done_b} !== 4'b0010) begin
          miscompares++; $display("FAIL wrap_b got %b exp 0010", {idx_b, playing_b, done_b});
        end
      end
      start = 1'b0;
    end
    vectors += 2;
    if (rises !== 2) begin miscompares++; $display("FAIL loop_replays got %0d exp 2", rises); end
    if (saw_done !== 1'b0) begin miscompares++; $display("FAIL loop_done got 1 exp 0"); end
    loop_en = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_abort_start;
    start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors += 2;
      if (obs_a !== expv(0)) begin miscompares++; $display("FAIL abort_a c=%0d got %h exp %h", c, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin miscompares++; $display("FAIL abort_b c=%0d got %h exp %h", c, obs_b, expv(1)); end
      if (c >= 5) begin
        vectors++;
        if ({note_a, stop_a, playing_a} !== {7'b0, 1'b1, 1'b0}) begin
          miscompares++; $display("FAIL abort_idle c=%0d got %b exp 000000010", c, {note_a, stop_a, playing_a});
        end
      end
      start = (c == 0 || c == 4);
      abort = (c == 4);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_pause;
    int do_cyc = 0, held = 0;
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors += 2;
      if (obs_a !== expv(0)) begin miscompares++; $display("FAIL pause_a c=%0d got %h exp %h", c, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin miscompares++; $display("FAIL pause_b c=%0d got %h exp %h", c, obs_b, expv(1)); end
      if (note_a == DO) do_cyc++;
      if (note_a == DO && stop_a) held++;
      start = 1'b0;
      pause = (c >= 4 && c < 9);
    end
    vectors += 2;
    if (do_cyc !== 13) begin miscompares++; $display("FAIL pause_len got %0d exp 13", do_cyc); end
    if (held !== 5) begin miscompares++; $display("FAIL pause_stop got %0d exp 5", held); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_speed;
    for (int s = 1; s <= 2; s++) begin
      int re_cyc = 0;
      int exp_re = (s == 1) ? 8 : 38;
      speed = 2'(s); start = 1'b1;
      for (int c = 0; c < 110; c++) begin
        @(negedge clk);
        vectors += 2;
        if (obs_a !== expv(0)) begin miscompares++; $display("FAIL speed%0d_a c=%0d got %h exp %h", s, c, obs_a, expv(0)); end
        if (obs_b !== expv(1)) begin miscompares++; $display("FAIL speed%0d_b c=%0d got %h exp %h", s, c, obs_b, expv(1)); end
        if (note_a == RE) re_cyc++;
        start = 1'b0;
      end
      vectors++;
      if (re_cyc !== exp_re) begin miscompares++; $display("FAIL speed%0d_tone got %0d exp %0d", s, re_cyc, exp_re); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    speed = 2'b00;
  endtask

  task automatic test_reset_midplay;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors += 2;
      if (obs_a !== expv(0)) begin miscompares++; $display("FAIL rstmid_a c=%0d got %h exp %h", c, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin miscompares++; $display("FAIL rstmid_b c=%0d got %h exp %h", c, obs_b, expv(1)); end
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (obs_a !== RST_V) begin miscompares++; $display("FAIL async_reset_a got %h exp %h", obs_a, RST_V); end
    if (obs_b !== RST_V) begin miscompares++; $display("FAIL async_reset_b got %h exp %h", obs_b, RST_V); end
    if (expv(0) !== obs_a) begin miscompares++; $display("FAIL async_reset_model got %h exp %h", obs_a, expv(0)); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      vectors += 2;
      if (obs_a !== expv(0)) begin miscompares++; $display("FAIL rand_a c=%0d got %h exp %h", c, obs_a, expv(0)); end
      if (obs_b !== expv(1)) begin miscompares++; $display("FAIL rand_b c=%0d got %h exp %h", c, obs_b, expv(1)); end
      start = ($urandom_range(0, 19) == 0);
      abort = ($urandom_range(0, 149) == 0);
      pause = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = 1'($urandom);
      if ($urandom_range(0, 29) == 0) speed = 2'($urandom_range(0, 3));
    end
    start = 1'b0; abort = 1'b0; pause = 1'b0;
  endtask

  initial begin
    logic [55:0] img;
    for (int i = 0; i < 4; i++) begin
      img = ROM_A;
      rom[0][i] = img[14*i +: 14];
      img = ROM_B;
      rom[1][i] = img[14*i +: 14];
    end
    test_reset;
    test_basic_song;
    test_loop;
    test_abort_start;
    test_pause;
    test_speed;
    test_reset_midplay;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
